// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mp3_pkg
// Description : Shared constants and types for the granule reorder stage.
//               Short-block scalefactor-band tables (44.1 kHz only), granule
//               length, reorder mode / state encodings and a mode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mp3_pkg;

    localparam int GRANULE_LEN = 576;

    // Last output index of a granule, in the 10-bit address domain.
    localparam logic [9:0] LAST_POS = 10'(GRANULE_LEN - 1);

    // Mixed blocks: the first 36 lines are long-block lines (sfb 0..2 of the
    // short layout span 3*12 = 36 lines), the short sequence resumes at sfb 3.
    localparam logic [9:0] MIXED_LONG_LEN  = 10'd36;
    localparam logic [3:0] MIXED_FIRST_SFB = 4'd3;
    localparam logic [3:0] SFB_LAST        = 4'd12;

    // Short-block band widths and per-window band starts, 44.1 kHz.
    localparam logic [9:0] SFB_S_WIDTH [0:12] = '{
        10'd4, 10'd4, 10'd4, 10'd4, 10'd6, 10'd8, 10'd10,
        10'd12, 10'd14, 10'd18, 10'd22, 10'd30, 10'd56
    };
    localparam logic [9:0] SFB_S_START [0:12] = '{
        10'd0, 10'd4, 10'd8, 10'd12, 10'd16, 10'd22, 10'd30,
        10'd40, 10'd52, 10'd66, 10'd84, 10'd106, 10'd136
    };

    typedef enum logic [1:0] {
        LONG  = 2'd0,
        SHORT = 2'd1,
        MIXED = 2'd2
    } reorder_mode_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } reorder_state_t;

    // Base of a band in the granule buffer: three windows of the band are
    // stored back to back, so the band begins at 3*start. Indexed by a
    // constant table, this folds into a 13-entry ROM.
    function automatic logic [9:0] sfb_base(input logic [3:0] sfb);
        return 10'd3 * SFB_S_START[sfb];
    endfunction

    function automatic reorder_mode_t decode_mode(
        input logic       wsf,
        input logic [1:0] bt,
        input logic       mixed
    );
        if (wsf && (bt == 2'd2)) begin
            return mixed ? MIXED : SHORT;
        end
        return LONG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/short_block_reorder_if.sv
`default_nettype none
// ============================================================================
// Interface   : short_block_reorder_if
// Description : Sample-in / sample-out bundle of the granule reorder stage.
//   Input side : side info (window_switching_flag_in, block_type_in,
//                mixed_block_flag_in), din, din_v, din_ready (back-pressure)
//   Output side: dout, dout_pos, dout_v, dout_last, overflow (sticky)
//   master = upstream/downstream environment, slave = the reorder block.
// Revision    : 1.0 - initial release
// ============================================================================
interface short_block_reorder_if;
    logic        window_switching_flag_in;
    logic [1:0]  block_type_in;
    logic        mixed_block_flag_in;
    logic [31:0] din;
    logic        din_v;
    logic        din_ready;
    logic [31:0] dout;
    logic [9:0]  dout_pos;
    logic        dout_v;
    logic        dout_last;
    logic        overflow;

    modport master (
        output window_switching_flag_in, block_type_in, mixed_block_flag_in,
        output din, din_v,
        input  din_ready, dout, dout_pos, dout_v, dout_last, overflow
    );

    modport slave (
        input  window_switching_flag_in, block_type_in, mixed_block_flag_in,
        input  din, din_v,
        output din_ready, dout, dout_pos, dout_v, dout_last, overflow
    );
endinterface
`default_nettype wire

// File: rtl/reorder_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : reorder_addr_gen
// Description : Read-address sequencer for one granule drain. After a start
//               pulse it issues 576 read addresses on consecutive cycles.
//               Short sequence walks (sfb, i, win) with win innermost:
//               addr = 3*start[sfb] + win*width[sfb] + i.
//   start      : one-cycle pulse, begins a drain
//   mode       : LONG (identity), SHORT (sfb 0..12), MIXED (36 identity
//                lines, then short sequence from sfb 3)
//   rd_addr    : buffer read address, valid with issue_v
//   issue_pos  : output frequency index 0..575 of this issue
//   issue_last : high with issue_pos == 575
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_addr_gen
    import mp3_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire reorder_mode_t mode,
    output logic [9:0]         rd_addr,
    output logic               issue_v,
    output logic [9:0]         issue_pos,
    output logic               issue_last
);

    logic       r_active;
    logic [9:0] r_pos;
    logic [3:0] r_sfb;
    logic [5:0] r_i;
    logic [1:0] r_win;

    logic       w_go;
    logic       w_identity;
    logic [9:0] w_width;
    logic [9:0] w_short_addr;

    // The issue on the start cycle itself keeps the drain latency minimal.
    assign w_go       = start | r_active;
    assign w_identity = (mode == LONG) ||
                        ((mode == MIXED) && (r_pos < MIXED_LONG_LEN));
    assign w_width    = SFB_S_WIDTH[r_sfb];
    assign w_short_addr = sfb_base(r_sfb) + ({8'd0, r_win} * w_width) +
                          {4'd0, r_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_pos      <= '0;
            r_sfb      <= '0;
            r_i        <= '0;
            r_win      <= '0;
            rd_addr    <= '0;
            issue_v    <= 1'b0;
            issue_pos  <= '0;
            issue_last <= 1'b0;
        end else begin
            issue_v    <= w_go;
            issue_last <= w_go && (r_pos == LAST_POS);
            if (w_go) begin
                rd_addr   <= w_identity ? r_pos : w_short_addr;
                issue_pos <= r_pos;
                if (r_pos == LAST_POS) begin
                    r_active <= 1'b0;
                    r_pos    <= '0;
                end else begin
                    r_active <= 1'b1;
                    r_pos    <= r_pos + 10'd1;
                end
                // Band counters advance only on short-sequence issues, so the
                // mixed long prefix leaves them parked at sfb 3.
                if (!w_identity) begin
                    if (r_win == 2'd2) begin
                        r_win <= 2'd0;
                        if ({4'd0, r_i} == (w_width - 10'd1)) begin
                            r_i <= '0;
                            if (r_sfb != SFB_LAST) begin
                                r_sfb <= r_sfb + 4'd1;
                            end
                        end else begin
                            r_i <= r_i + 6'd1;
                        end
                    end else begin
                        r_win <= r_win + 2'd1;
                    end
                end
            end else begin
                // Idle: keep the counters preset for the next drain. The mode
                // is latched long before the next start pulse.
                r_sfb <= (mode == SHORT) ? 4'd0 : MIXED_FIRST_SFB;
                r_i   <= '0;
                r_win <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xilinx_single_port_ram_read_first.sv
`default_nettype none
// ============================================================================
// Module      : xilinx_single_port_ram_read_first
// Description : Single-port block RAM, read-first. Optional output register
//               (HIGH_PERFORMANCE: 2-cycle read latency, output reset by
//               rsta; LOW_LATENCY: 1-cycle read latency).
//   addra/dina/wea/ena : port A address, write data, write and enable
//   rsta/regcea        : output register reset / clock enable
//   douta              : read data
// Revision    : 1.0 - initial release
// ============================================================================
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH       = 32,
    parameter int RAM_DEPTH       = 576,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  wire logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  wire logic [RAM_WIDTH-1:0]         dina,
    input  wire logic                         clka,
    input  wire logic                         wea,
    input  wire logic                         ena,
    input  wire logic                         rsta,
    input  wire logic                         regcea,
    output logic      [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] r_ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_ram[addra] <= dina;
            end
            r_ram_data <= r_ram[addra];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_output_register
        assign douta = r_ram_data;
    end else begin : g_output_register
        logic [RAM_WIDTH-1:0] r_douta;
        always_ff @(posedge clka) begin
            if (rsta) begin
                r_douta <= '0;
            end else if (regcea) begin
                r_douta <= r_ram_data;
            end
        end
        assign douta = r_douta;
    end

endmodule
`default_nettype wire

// File: rtl/short_block_reorder.sv
`default_nettype none
// ============================================================================
// Module      : short_block_reorder
// Description : Buffers one 576-sample granule of requantized Q2.30 samples
//               and re-emits it in frequency-interleaved order for short
//               blocks, partially for mixed blocks, unchanged for long.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : short_block_reorder_if.slave - side info, din/din_v/din_ready
//              in; dout/dout_pos/dout_v/dout_last/overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module short_block_reorder
    import mp3_pkg::*;
#(
    parameter int RAM_LATENCY = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    short_block_reorder_if.slave bus
);

    reorder_state_t r_state;
    reorder_mode_t  r_mode;
    logic [9:0]     r_wr_cnt;
    logic           r_din_ready;
    logic           r_overflow;
    logic           r_start;

    logic [9:0]     w_rd_addr;
    logic           w_issue_v;
    logic [9:0]     w_issue_pos;
    logic           w_issue_last;
    logic [9:0]     w_ram_addr;
    logic           w_ram_we;
    logic [31:0]    w_ram_dout;

    // Issue-side qualifiers delayed to line up with the RAM read data.
    logic [RAM_LATENCY-1:0] r_v_pipe;
    logic [RAM_LATENCY-1:0] r_last_pipe;
    logic [9:0]             r_pos_pipe [RAM_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_mode      <= LONG;
            r_wr_cnt    <= '0;
            r_din_ready <= 1'b1;
            r_overflow  <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (bus.din_v && !r_din_ready) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                FILL: begin
                    if (bus.din_v) begin
                        if (r_wr_cnt == '0) begin
                            r_mode <= decode_mode(bus.window_switching_flag_in,
                                                  bus.block_type_in,
                                                  bus.mixed_block_flag_in);
                        end
                        if (r_wr_cnt == LAST_POS) begin
                            r_wr_cnt    <= '0;
                            r_state     <= DRAIN;
                            r_din_ready <= 1'b0;
                            r_start     <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_issue_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Re-open the input on the cycle after dout_last.
                    if (r_last_pipe[RAM_LATENCY-1]) begin
                        r_state     <= FILL;
                        r_din_ready <= 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_pipe    <= '0;
            r_last_pipe <= '0;
            for (int k = 0; k < RAM_LATENCY; k++) begin
                r_pos_pipe[k] <= '0;
            end
        end else begin
            r_v_pipe[0]    <= w_issue_v;
            r_last_pipe[0] <= w_issue_last;
            r_pos_pipe[0]  <= w_issue_pos;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_v_pipe[k]    <= r_v_pipe[k-1];
                r_last_pipe[k] <= r_last_pipe[k-1];
                r_pos_pipe[k]  <= r_pos_pipe[k-1];
            end
        end
    end

    reorder_addr_gen u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (r_start),
        .mode       (r_mode),
        .rd_addr    (w_rd_addr),
        .issue_v    (w_issue_v),
        .issue_pos  (w_issue_pos),
        .issue_last (w_issue_last)
    );

    // Fill and drain never overlap, so one port serves both.
    assign w_ram_addr = (r_state == FILL) ? r_wr_cnt : w_rd_addr;
    assign w_ram_we   = (r_state == FILL) && bus.din_v;

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (32),
        .RAM_DEPTH       (GRANULE_LEN),
        .RAM_PERFORMANCE ((RAM_LATENCY == 1) ? "LOW_LATENCY" : "HIGH_PERFORMANCE")
    ) u_buffer (
        .addra  (w_ram_addr),
        .dina   (bus.din),
        .clka   (clk),
        .wea    (w_ram_we),
        .ena    (1'b1),
        .rsta   (rst),
        .regcea (1'b1),
        .douta  (w_ram_dout)
    );

    assign bus.din_ready = r_din_ready;
    assign bus.overflow  = r_overflow;
    assign bus.dout      = w_ram_dout;
    assign bus.dout_v    = r_v_pipe[RAM_LATENCY-1];
    assign bus.dout_last = r_last_pipe[RAM_LATENCY-1];
    assign bus.dout_pos  = r_pos_pipe[RAM_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_short_block_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_short_block_reorder
// Description : Self-checking bench for short_block_reorder. Each granule
//               pushes its expected (pos, data) stream into a scoreboard
//               queue; the drain pops and compares every output cycle.
//               Directed spot values cover the short and mixed patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_short_block_reorder;

    localparam int c_N       = 576;
    localparam int c_LATENCY = 2;
    localparam int c_WID [13] = '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56};
    localparam int c_STA [13] = '{0, 4, 8, 12, 16, 22, 30, 40, 52, 66, 84, 106, 136};
    localparam int c_M_LONG  = 0;
    localparam int c_M_SHORT = 1;
    localparam int c_M_MIXED = 2;

    logic clk = 1'b0;
    logic rst;

    short_block_reorder_if bus ();

    short_block_reorder #(.RAM_LATENCY(c_LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [41:0] exp_q [$];
    int          map_tbl [c_N];
    logic [31:0] got [c_N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected read order, built straight from the band tables.
    task automatic build_map(input int mode);
        int p;
        int s0;
        p = 0;
        if (mode == c_M_LONG) begin
            for (int k = 0; k < c_N; k++) map_tbl[k] = k;
            return;
        end
        s0 = (mode == c_M_SHORT) ? 0 : 3;
        for (int k = 0; k < 3 * c_STA[s0]; k++) begin
            map_tbl[p] = k;
            p++;
        end
        for (int s = s0; s < 13; s++)
            for (int i = 0; i < c_WID[s]; i++)
                for (int w = 0; w < 3; w++) begin
                    map_tbl[p] = 3 * c_STA[s] + w * c_WID[s] + i;
                    p++;
                end
    endtask

    task automatic send_granule(input int mode, input int base, input int gap);
        int bad_ready;
        bad_ready = 0;
        bus.window_switching_flag_in = (mode != c_M_LONG);
        bus.block_type_in            = (mode != c_M_LONG) ? 2'd2 : 2'd0;
        bus.mixed_block_flag_in      = (mode == c_M_MIXED);
        for (int k = 0; k < c_N; k++) begin
            if (k > 0) repeat (gap) tick();
            if (bus.din_ready !== 1'b1) bad_ready++;
            bus.din   = 32'(base + k);
            bus.din_v = 1'b1;
            tick();
            bus.din_v = 1'b0;
        end
        check("din_ready_fill", 32'(bad_ready), 32'd0);
        check("din_ready_low_after_fill", 32'(bus.din_ready), 32'd0);
        build_map(mode);
        for (int p = 0; p < c_N; p++) begin
            exp_q.push_back({10'(p), 32'(base + map_tbl[p])});
        end
    endtask

    task automatic drain(input string tag, input bit inject, input int stop_at);
        int          c;
        logic [41:0] e;
        c = 0;
        while (bus.dout_v !== 1'b1 && c < 16) begin
            tick();
            c++;
        end
        check({tag, "_latency"}, 32'(c), 32'(1 + c_LATENCY));
        for (int p = 0; p < stop_at; p++) begin
            if (inject && p == 50) begin
                bus.din   = 32'hDEADBEEF;
                bus.din_v = 1'b1;
            end
            if (inject && p == 53) bus.din_v = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check({tag, "_valid"}, 32'(bus.dout_v), 32'd1);
            check({tag, "_pos"}, 32'(bus.dout_pos), 32'(e[41:32]));
            check({tag, "_data"}, bus.dout, e[31:0]);
            check({tag, "_last"}, 32'(bus.dout_last), 32'(p == c_N - 1));
            if (p == c_N - 1) check({tag, "_ready_at_last"}, 32'(bus.din_ready), 32'd0);
            got[p] = bus.dout;
            tick();
        end
        if (stop_at == c_N) begin
            check({tag, "_ready_after_last"}, 32'(bus.din_ready), 32'd1);
            check({tag, "_valid_after_last"}, 32'(bus.dout_v), 32'd0);
            check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        int          bad;
        int          short_pos [10] = '{0, 1, 2, 3, 4, 5, 408, 409, 410, 575};
        logic [31:0] short_val [10] = '{0, 4, 8, 1, 5, 9, 408, 464, 520, 575};
        int          mixed_pos [4]  = '{36, 37, 38, 39};
        logic [31:0] mixed_val [4]  = '{36, 40, 44, 37};

        rst = 1'b1;
        bus.window_switching_flag_in = 1'b0;
        bus.block_type_in            = 2'd0;
        bus.mixed_block_flag_in      = 1'b0;
        bus.din                      = '0;
        bus.din_v                    = 1'b0;
        repeat (3) tick();
        check("rst_dout_v", 32'(bus.dout_v), 32'd0);
        check("rst_dout", bus.dout, 32'd0);
        check("rst_dout_pos", 32'(bus.dout_pos), 32'd0);
        check("rst_dout_last", 32'(bus.dout_last), 32'd0);
        check("rst_din_ready", 32'(bus.din_ready), 32'd1);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Long block, gap-free: identity.
        send_granule(c_M_LONG, 0, 0);
        drain("long", 1'b0, c_N);

        // Short block with directed spot values.
        send_granule(c_M_SHORT, 0, 0);
        drain("short", 1'b0, c_N);
        for (int k = 0; k < 10; k++) check("short_spot", got[short_pos[k]], short_val[k]);

        // Mixed block: long prefix then short sequence from sfb 3.
        send_granule(c_M_MIXED, 0, 0);
        drain("mixed", 1'b0, c_N);
        bad = 0;
        for (int k = 0; k < 36; k++) if (got[k] !== 32'(k)) bad++;
        check("mixed_identity_prefix", 32'(bad), 32'd0);
        for (int k = 0; k < 4; k++) check("mixed_spot", got[mixed_pos[k]], mixed_val[k]);

        // Stalled input: samples on alternate cycles, same output.
        send_granule(c_M_SHORT, 0, 1);
        drain("stalled", 1'b0, c_N);
        for (int k = 0; k < 10; k++) check("stalled_spot", got[short_pos[k]], short_val[k]);

        // Overflow: din_v during drain is dropped and flagged.
        check("overflow_before", 32'(bus.overflow), 32'd0);
        send_granule(c_M_LONG, 32'h100, 0);
        drain("ovf", 1'b1, c_N);
        check("overflow_set", 32'(bus.overflow), 32'd1);
        send_granule(c_M_SHORT, 32'h1000, 0);
        drain("post_ovf", 1'b0, c_N);
        bad = 0;
        for (int k = 0; k < c_N; k++) if (got[k] === 32'hDEADBEEF) bad++;
        check("no_deadbeef", 32'(bad), 32'd0);
        check("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Reset after 100 outputs of a drain.
        send_granule(c_M_SHORT, 32'h3000, 0);
        drain("pre_rst", 1'b0, 100);
        rst = 1'b1;
        tick();
        check("midrst_dout_v", 32'(bus.dout_v), 32'd0);
        check("midrst_din_ready", 32'(bus.din_ready), 32'd1);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.dout_v !== 1'b0) bad++;
        end
        check("midrst_no_valid", 32'(bad), 32'd0);
        send_granule(c_M_MIXED, 32'h2000, 0);
        drain("after_rst", 1'b0, c_N);
        check("after_rst_spot", got[36], 32'h2000 + 32'd36);
        check("after_rst_spot2", got[37], 32'h2000 + 32'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
